// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle sequencer: state enum, mux-select
// constants and the flag-only compare opcodes.
package ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXECR  = 4'd2,
    EXECI  = 4'd3,
    ALUWB  = 4'd4,
    MEMADR = 4'd5,
    MEMRD  = 4'd6,
    MEMWB  = 4'd7,
    MEMWR  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] OPC_TST = 4'b1000;
  localparam logic [3:0] OPC_TEQ = 4'b1001;
  localparam logic [3:0] OPC_CMP = 4'b1010;
  localparam logic [3:0] OPC_CMN = 4'b1011;

  // Compare-class opcodes only update flags, never the register file.
  function automatic logic is_compare(input logic [3:0] opc);
    return (opc == OPC_TST) || (opc == OPC_TEQ) ||
           (opc == OPC_CMP) || (opc == OPC_CMN);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface multicycle_ctrl_fsm_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic       cond_pass;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [1:0] flag_write;
  logic       instr_done;

  modport master (
    input  op, funct, cond_pass, mem_ready,
    output pc_write, adr_src, mem_read, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, reg_write, flag_write, instr_done
  );

  modport slave (
    output op, funct, cond_pass, mem_ready,
    input  pc_write, adr_src, mem_read, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, reg_write, flag_write, instr_done
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle fetch/decode/execute/memory/writeback sequencer; Moore outputs
// except the memory-ready qualified FETCH writes and the MEMWR completion.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int ST_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_fsm_if.master bus,
  output logic [ST_W-1:0]       state
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  assign state = rst ? '0 : ST_W'(state_q);

  always_comb begin
    state_d        = FETCH;
    bus.pc_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.result_src = RES_ALUOUT;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_RD2;
    bus.alu_op     = ALUOP_ADD;
    bus.reg_write  = 1'b0;
    bus.flag_write = 2'b00;
    bus.instr_done = 1'b0;

    // Reset masks every output so an aborted instruction leaves no side effects.
    if (!rst) begin
      case (state_q)
        FETCH: begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write   = 1'b1;
            bus.pc_write   = 1'b1;
            bus.alu_src_a  = 1'b1;
            bus.alu_src_b  = SRCB_FOUR;
            bus.alu_op     = ALUOP_ADD;
            bus.result_src = RES_ALU;
            state_d        = DECODE;
          end else begin
            state_d = FETCH;
          end
        end
        DECODE: begin
          if (!bus.cond_pass) begin
            bus.instr_done = 1'b1;
          end else begin
            case (bus.op)
              2'b00:   state_d = bus.funct[5] ? EXECI : EXECR;
              2'b01:   state_d = MEMADR;
              2'b10:   state_d = BRANCH;
              default: bus.instr_done = 1'b1;
            endcase
          end
        end
        EXECR, EXECI: begin
          bus.alu_src_b  = (state_q == EXECI) ? SRCB_IMM : SRCB_RD2;
          bus.alu_op     = ALUOP_FUNCT;
          bus.flag_write = {2{bus.funct[0]}};
          state_d        = ALUWB;
        end
        ALUWB: begin
          bus.result_src = RES_ALUOUT;
          bus.reg_write  = !is_compare(bus.funct[4:1]);
          bus.instr_done = 1'b1;
        end
        MEMADR: begin
          bus.alu_src_b = SRCB_IMM;
          bus.alu_op    = ALUOP_ADD;
          state_d       = bus.funct[0] ? MEMRD : MEMWR;
        end
        MEMRD: begin
          bus.adr_src  = 1'b1;
          bus.mem_read = 1'b1;
          state_d      = bus.mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          bus.result_src = RES_DATA;
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        MEMWR: begin
          bus.adr_src    = 1'b1;
          bus.mem_write  = 1'b1;
          bus.instr_done = bus.mem_ready;
          state_d        = bus.mem_ready ? FETCH : MEMWR;
        end
        BRANCH: begin
          bus.alu_src_b  = SRCB_IMM;
          bus.alu_op     = ALUOP_ADD;
          bus.result_src = RES_ALU;
          bus.pc_write   = 1'b1;
          bus.reg_write  = bus.funct[4];
          bus.instr_done = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule
